thermal_frame_reader: RTL and testbench

Sequencer that drives the I2C controller to pull one full thermal frame from the 8x8 array sensor and streams it out as 12-bit pixels. It sits directly upstream of the I2C controller: it owns the controller's command inputs (address, mode, transmit data, pending flags, start) and consumes its received bytes. Downstream, pixel consumers such as the frame buffer or colour mapper receive a valid-qualified pixel stream with index and end-of-frame.

---
 rtl/thermal_frame_reader.sv | 162 ++++++++++++++++
 tb/tb_thermal_frame_reader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/thermal_frame_reader.sv
// thermal_frame_reader: sequences the I2C controller through a pixel-pointer
// write followed by a burst read of one 8x8 thermal frame, and streams the
// received byte pairs out as signed 12-bit pixels with index and end-of-frame.
module thermal_frame_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_request,
  input  logic        i2c_busy,
  input  logic        i2c_byte_done,
  input  logic [7:0]  i2c_received_data,
  output logic [7:0]  i2c_address,
  output logic        i2c_write_mode,
  output logic [7:0]  i2c_transmit_data,
  output logic        i2c_write_pending,
  output logic        i2c_read_pending,
  output logic        i2c_start_transfer,
  output logic        pixel_valid,
  output logic [11:0] pixel_data,
  output logic [5:0]  pixel_index,
  output logic        frame_done,
  output logic        busy,
  output logic        error
);

  localparam logic [6:0]  SENSOR_ADDR    = 7'h69;
  localparam logic [7:0]  PIXEL_REG      = 8'h80;
  localparam int          PIXEL_COUNT    = 64;
  localparam int          TIMEOUT_CYCLES = 4095;
  localparam logic [7:0]  LAST_BYTE      = 8'(2 * PIXEL_COUNT - 1);
  localparam logic [11:0] TIMEOUT_LAST   = 12'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PTR_WR,
    PTR_END,
    RD,
    RD_END
  } state_t;

  state_t      state;
  logic [7:0]  byte_cnt;
  logic [7:0]  lo_reg;
  logic [11:0] timeout_cnt;

  // Single sequencer: owns every controller command and the pixel stream, all registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      byte_cnt           <= 8'd0;
      lo_reg             <= 8'd0;
      timeout_cnt        <= 12'd0;
      i2c_address        <= {SENSOR_ADDR, 1'b0};
      i2c_write_mode     <= 1'b0;
      i2c_transmit_data  <= 8'd0;
      i2c_write_pending  <= 1'b0;
      i2c_read_pending   <= 1'b0;
      i2c_start_transfer <= 1'b0;
      pixel_valid        <= 1'b0;
      pixel_data         <= 12'd0;
      pixel_index        <= 6'd0;
      frame_done         <= 1'b0;
      busy               <= 1'b0;
      error              <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;

      case (state)
        IDLE: begin
          timeout_cnt <= 12'd0;
          if (frame_request) begin
            state              <= PTR_WR;
            busy               <= 1'b1;
            byte_cnt           <= 8'd0;
            pixel_index        <= 6'd0;
            i2c_start_transfer <= 1'b1;
            i2c_write_mode     <= 1'b1;
            i2c_address        <= {SENSOR_ADDR, 1'b0};
            i2c_transmit_data  <= PIXEL_REG;
            i2c_write_pending  <= 1'b0;
            i2c_read_pending   <= 1'b0;
          end
        end

        PTR_WR: begin
          if (i2c_byte_done) begin
            i2c_start_transfer <= 1'b0;
            timeout_cnt        <= 12'd0;
            state              <= PTR_END;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            i2c_start_transfer <= 1'b0;
            i2c_read_pending   <= 1'b0;
            i2c_write_mode     <= 1'b0;
            i2c_transmit_data  <= 8'd0;
            error              <= 1'b1;
            state              <= RD_END;
          end else begin
            timeout_cnt <= timeout_cnt + 12'd1;
          end
        end

        PTR_END: begin
          if (!i2c_busy) begin
            state              <= RD;
            timeout_cnt        <= 12'd0;
            i2c_start_transfer <= 1'b1;
            i2c_write_mode     <= 1'b0;
            i2c_transmit_data  <= 8'd0;
            i2c_address        <= {SENSOR_ADDR, 1'b1};
            i2c_read_pending   <= (8'd0 < LAST_BYTE);
          end
        end

        RD: begin
          if (i2c_byte_done) begin
            timeout_cnt      <= 12'd0;
            byte_cnt         <= byte_cnt + 8'd1;
            i2c_read_pending <= ((byte_cnt + 8'd1) < LAST_BYTE);
            if (!byte_cnt[0]) begin
              lo_reg <= i2c_received_data;
            end else begin
              pixel_data  <= {i2c_received_data[3:0], lo_reg};
              pixel_index <= byte_cnt[6:1];
              pixel_valid <= 1'b1;
            end
            if (byte_cnt == LAST_BYTE) begin
              i2c_start_transfer <= 1'b0;
              i2c_read_pending   <= 1'b0;
              frame_done         <= 1'b1;
              state              <= RD_END;
            end
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            i2c_start_transfer <= 1'b0;
            i2c_read_pending   <= 1'b0;
            error              <= 1'b1;
            state              <= RD_END;
          end else begin
            timeout_cnt <= timeout_cnt + 12'd1;
          end
        end

        RD_END: begin
          if (!i2c_busy) begin
            state             <= IDLE;
            busy              <= 1'b0;
            i2c_address       <= {SENSOR_ADDR, 1'b0};
            i2c_write_mode    <= 1'b0;
            i2c_transmit_data <= 8'd0;
            i2c_read_pending  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_thermal_frame_reader.sv
// Bench for thermal_frame_reader: a task-driven I2C controller model feeds
// directed byte patterns; expected pixels go into a scoreboard queue and a
// separate monitor checks each pixel strobe against it.
module tb_thermal_frame_reader;

  logic        clk;
  logic        reset;
  logic        frame_request;
  logic        i2c_busy;
  logic        i2c_byte_done;
  logic [7:0]  i2c_received_data;
  logic [7:0]  i2c_address;
  logic        i2c_write_mode;
  logic [7:0]  i2c_transmit_data;
  logic        i2c_write_pending;
  logic        i2c_read_pending;
  logic        i2c_start_transfer;
  logic        pixel_valid;
  logic [11:0] pixel_data;
  logic [5:0]  pixel_index;
  logic        frame_done;
  logic        busy;
  logic        error;

  typedef struct packed {
    logic [11:0] data;
    logic [5:0]  idx;
    logic        last;
  } pix_t;

  pix_t expected_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   frame_done_count = 0;
  int   error_count = 0;

  thermal_frame_reader dut (
    .clk                (clk),
    .reset              (reset),
    .frame_request      (frame_request),
    .i2c_busy           (i2c_busy),
    .i2c_byte_done      (i2c_byte_done),
    .i2c_received_data  (i2c_received_data),
    .i2c_address        (i2c_address),
    .i2c_write_mode     (i2c_write_mode),
    .i2c_transmit_data  (i2c_transmit_data),
    .i2c_write_pending  (i2c_write_pending),
    .i2c_read_pending   (i2c_read_pending),
    .i2c_start_transfer (i2c_start_transfer),
    .pixel_valid        (pixel_valid),
    .pixel_data         (pixel_data),
    .pixel_index        (pixel_index),
    .frame_done         (frame_done),
    .busy               (busy),
    .error              (error)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case some bounded wait is itself broken
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: compare every pixel strobe with the head of the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (frame_done) frame_done_count++;
      if (error) error_count++;
      if (pixel_valid) begin
        if (expected_q.size() == 0) begin
          checkOutput("unexpected_pixel", 32'd1, 32'd0);
        end else begin
          pix_t e;
          e = expected_q.pop_front();
          checkOutput("pixel_data", 32'(pixel_data), 32'(e.data));
          checkOutput("pixel_index", 32'(pixel_index), 32'(e.idx));
          checkOutput("frame_done", 32'(frame_done), 32'(e.last));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    frame_request = 1'b1;
    tick();
    frame_request = 1'b0;
  endtask

  task automatic push_pixels(input int n, input logic [7:0] lo, input logic [7:0] hi, input bit full);
    for (int i = 0; i < n; i++) begin
      pix_t p;
      p.data = {hi[3:0], lo};
      p.idx  = 6'(i);
      p.last = full && (i == 63);
      expected_q.push_back(p);
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (!i2c_start_transfer && n < 50) begin
      tick();
      n++;
    end
    checkOutput("start_rise", 32'(i2c_start_transfer), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] data, input bit check_pend, input logic exp_pend);
    tick();
    tick();
    if (check_pend) checkOutput("read_pending", 32'(i2c_read_pending), 32'(exp_pend));
    i2c_received_data = data;
    i2c_byte_done = 1'b1;
    tick();
    i2c_byte_done = 1'b0;
    i2c_received_data = 8'h00;
  endtask

  task automatic pointer_phase();
    wait_start();
    i2c_busy = 1'b1;
    checkOutput("ptr_address", 32'(i2c_address), 32'hD2);
    checkOutput("ptr_tx_data", 32'(i2c_transmit_data), 32'h80);
    checkOutput("ptr_write_mode", 32'(i2c_write_mode), 32'd1);
    checkOutput("ptr_write_pending", 32'(i2c_write_pending), 32'd0);
    send_byte(8'h00, 1'b0, 1'b0);
    checkOutput("ptr_start_drop", 32'(i2c_start_transfer), 32'd0);
    tick();
    i2c_busy = 1'b0;
  endtask

  task automatic read_phase(input int n_bytes, input logic [7:0] lo, input logic [7:0] hi, input int req_at);
    wait_start();
    i2c_busy = 1'b1;
    checkOutput("rd_address", 32'(i2c_address), 32'hD3);
    checkOutput("rd_write_mode", 32'(i2c_write_mode), 32'd0);
    for (int k = 0; k < n_bytes; k++) begin
      if (k == req_at) applyStimulus();
      send_byte((k % 2 == 0) ? lo : hi, 1'b1, (k < 127));
    end
  endtask

  task automatic release_bus();
    int n = 0;
    while (i2c_start_transfer && n < 50) begin
      tick();
      n++;
    end
    checkOutput("start_released", 32'(i2c_start_transfer), 32'd0);
    tick();
    i2c_busy = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    checkOutput("busy_clear", 32'(busy), 32'd0);
  endtask

  // Main directed sequence
  initial begin
    int cnt;
    reset = 1'b0;
    frame_request = 1'b0;
    i2c_busy = 1'b0;
    i2c_byte_done = 1'b0;
    i2c_received_data = 8'h00;
    tick();
    tick();
    checkOutput("rst_address", 32'(i2c_address), 32'hD2);
    checkOutput("rst_start", 32'(i2c_start_transfer), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    checkOutput("rst_tx_data", 32'(i2c_transmit_data), 32'd0);
    reset = 1'b1;
    tick();

    $display("[TB] frame 1: lo=90 hi=01 with stray request during read");
    push_pixels(64, 8'h90, 8'h01, 1'b1);
    applyStimulus();
    checkOutput("req_to_start", 32'(i2c_start_transfer), 32'd1);
    checkOutput("busy_high", 32'(busy), 32'd1);
    pointer_phase();
    read_phase(128, 8'h90, 8'h01, 60);
    release_bus();
    tick();
    checkOutput("no_queued_request", 32'(busy), 32'd0);
    checkOutput("frame_done_count_1", 32'(frame_done_count), 32'd1);

    $display("[TB] frame 2: negative pixels lo=FC hi=0F");
    push_pixels(64, 8'hFC, 8'h0F, 1'b1);
    applyStimulus();
    pointer_phase();
    read_phase(128, 8'hFC, 8'h0F, -1);
    release_bus();
    checkOutput("frame_done_count_2", 32'(frame_done_count), 32'd2);

    $display("[TB] frame 3: back-to-back request, stall after 10 bytes");
    push_pixels(5, 8'h34, 8'hA2, 1'b0);
    applyStimulus();
    checkOutput("b2b_accept", 32'(i2c_start_transfer), 32'd1);
    pointer_phase();
    read_phase(10, 8'h34, 8'hA2, -1);
    cnt = 0;
    while (!error && cnt < 5000) begin
      tick();
      cnt++;
    end
    checkOutput("error_pulse", 32'(error), 32'd1);
    checkOutput("timeout_latency_ok", 32'(cnt >= 4094 && cnt <= 4096), 32'd1);
    checkOutput("abort_start", 32'(i2c_start_transfer), 32'd0);
    checkOutput("abort_read_pending", 32'(i2c_read_pending), 32'd0);
    tick();
    checkOutput("busy_held_until_release", 32'(busy), 32'd1);
    release_bus();
    checkOutput("frame_done_count_3", 32'(frame_done_count), 32'd2);
    checkOutput("error_count", 32'(error_count), 32'd1);

    $display("[TB] frame 4: asynchronous reset mid-read");
    push_pixels(2, 8'h55, 8'h07, 1'b0);
    applyStimulus();
    pointer_phase();
    read_phase(4, 8'h55, 8'h07, -1);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_start", 32'(i2c_start_transfer), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_address", 32'(i2c_address), 32'hD2);
    checkOutput("mid_rst_read_pending", 32'(i2c_read_pending), 32'd0);
    checkOutput("mid_rst_pixel_data", 32'(pixel_data), 32'd0);
    i2c_busy = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    checkOutput("post_rst_idle", 32'(busy), 32'd0);
    checkOutput("scoreboard_drained", 32'(expected_q.size()), 32'd0);
    checkOutput("frame_done_total", 32'(frame_done_count), 32'd2);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
